// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions: register-specifier width, forwarding select encodings
// and the source/destination match helpers used by the hazard logic.
package hazard_unit_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef logic [REG_AW-1:0] reg_t;

    // $0 is hardwired to zero, so it never matches a producing stage
    function automatic logic srcMatches(input reg_t src, input reg_t wr, input logic we);
        return (src != '0) && we && (src == wr);
    endfunction

    function automatic logic [1:0] fwdSelect(input reg_t src,
                                             input reg_t wrM, input logic rwM,
                                             input reg_t wrW, input logic rwW);
        if (srcMatches(src, wrM, rwM))
            return FWD_MEM;
        else if (srcMatches(src, wrW, rwW))
            return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle of pipeline-stage fields read by the hazard unit and the controls it returns.
// master = pipeline side, slave = hazard unit side.
interface hazard_unit_if;
    import hazard_unit_pkg::*;

    reg_t        RsD, RtD, RsE, RtE;
    reg_t        WriteRegE, WriteRegM, WriteRegW;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic        MemtoRegE, MemtoRegM;
    logic        BranchD, MdStartE, MdUseD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        ForwardAD, ForwardBD;
    logic        StallF, StallD, FlushE;
    logic        MdBusy;
    logic [31:0] StallCount;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, MdStartE, MdUseD,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, FlushE, MdBusy, StallCount
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, MdStartE, MdUseD,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
               StallF, StallD, FlushE, MdBusy, StallCount
    );

endinterface

// File: rtl/hazard_unit_mdu_busy_tracker.sv
// Counts down the cycles an issued mul/div op keeps the HI/LO unit busy.
module mdu_busy_tracker #(
    parameter int MDU_LATENCY = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic MdStartE,
    output logic MdBusy
);
    import hazard_unit_pkg::*;

    localparam int CW = $clog2(MDU_LATENCY + 1);

    logic [CW-1:0] r_cnt;

    // A start reloads unconditionally; pipeline stalls do not pause the unit
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (MdStartE)
            r_cnt <= CW'(MDU_LATENCY);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - CW'(1);
    end

    assign MdBusy = (r_cnt != '0);

endmodule

// File: rtl/hazard_unit.sv
// Forwarding selects and stall/flush controls for the 5-stage pipeline.
// Define HAZ_PERF_EN to build the saturating stall-cycle counter behind StallCount.
module hazard_unit #(
    parameter int MDU_LATENCY = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_unit_if.slave  hz
);
    import hazard_unit_pkg::*;

    logic w_lwStall;
    logic w_brStall;
    logic w_mdStall;
    logic w_stall;
    logic w_mdBusy;
    logic w_hitE;
    logic w_hitM;

    mdu_busy_tracker #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_busy_tracker (
        .clk      (clk),
        .reset    (reset),
        .MdStartE (hz.MdStartE),
        .MdBusy   (w_mdBusy)
    );

    assign hz.ForwardAE = fwdSelect(hz.RsE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
    assign hz.ForwardBE = fwdSelect(hz.RtE, hz.WriteRegM, hz.RegWriteM, hz.WriteRegW, hz.RegWriteW);
    assign hz.ForwardAD = srcMatches(hz.RsD, hz.WriteRegM, hz.RegWriteM);
    assign hz.ForwardBD = srcMatches(hz.RtD, hz.WriteRegM, hz.RegWriteM);

    // Load-use deliberately skips the $0 filter; a spurious one-cycle stall is harmless
    assign w_lwStall = hz.MemtoRegE && ((hz.RtE == hz.RsD) || (hz.RtE == hz.RtD));

    assign w_hitE    = srcMatches(hz.RsD, hz.WriteRegE, hz.RegWriteE) ||
                       srcMatches(hz.RtD, hz.WriteRegE, hz.RegWriteE);
    assign w_hitM    = srcMatches(hz.RsD, hz.WriteRegM, hz.MemtoRegM) ||
                       srcMatches(hz.RtD, hz.WriteRegM, hz.MemtoRegM);
    assign w_brStall = hz.BranchD && (w_hitE || w_hitM);

    assign w_mdStall = hz.MdUseD && (w_mdBusy || hz.MdStartE);
    assign w_stall   = w_lwStall || w_brStall || w_mdStall;

    assign hz.StallF = w_stall;
    assign hz.StallD = w_stall;
    assign hz.FlushE = w_stall;
    assign hz.MdBusy = w_mdBusy;

`ifdef HAZ_PERF_EN
    logic [31:0] r_stallCount;

    always_ff @(posedge clk) begin
        if (reset)
            r_stallCount <= '0;
        else if (w_stall && (r_stallCount != 32'hFFFF_FFFF))
            r_stallCount <= r_stallCount + 32'd1;
    end

    assign hz.StallCount = r_stallCount;
`else
    assign hz.StallCount = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MDU_LATENCY = 4).
// Expected values are hand-derived from the forwarding/stall rules.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

`ifdef HAZ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    hazard_unit_if hzIf ();

    hazard_unit #(
        .MDU_LATENCY (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hzIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [4:0] rsE, rtE, wrM, wrW;
        logic       rwM, rwW;
        logic [1:0] expA, expB;
    } fwdE_t;

    typedef struct {
        logic [4:0] rsD, rtD, wrM;
        logic       rwM;
        logic       expAD, expBD;
    } fwdD_t;

    task automatic clearInputs();
        hzIf.RsD = '0; hzIf.RtD = '0; hzIf.RsE = '0; hzIf.RtE = '0;
        hzIf.WriteRegE = '0; hzIf.WriteRegM = '0; hzIf.WriteRegW = '0;
        hzIf.RegWriteE = 1'b0; hzIf.RegWriteM = 1'b0; hzIf.RegWriteW = 1'b0;
        hzIf.MemtoRegE = 1'b0; hzIf.MemtoRegM = 1'b0;
        hzIf.BranchD = 1'b0; hzIf.MdStartE = 1'b0; hzIf.MdUseD = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        clearInputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clearInputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({hzIf.ForwardAE, hzIf.ForwardBE, hzIf.ForwardAD, hzIf.ForwardBD,
             hzIf.StallF, hzIf.StallD, hzIf.FlushE, hzIf.MdBusy} !== 10'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%b exp=0", {hzIf.ForwardAE, hzIf.ForwardBE,
                     hzIf.ForwardAD, hzIf.ForwardBD, hzIf.StallF, hzIf.StallD, hzIf.FlushE, hzIf.MdBusy});
        end
        checks++;
        if (hzIf.StallCount !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_stallcount got=%0d exp=0", hzIf.StallCount);
        end
        reset = 1'b0;
    endtask

    task automatic test_forward_execute();
        fwdE_t vec[6];
        vec[0] = '{rsE:5,  rtE:1,  wrM:5,  wrW:5,  rwM:1, rwW:1, expA:2'b10, expB:2'b00};
        vec[1] = '{rsE:2,  rtE:7,  wrM:3,  wrW:7,  rwM:1, rwW:1, expA:2'b00, expB:2'b01};
        vec[2] = '{rsE:0,  rtE:0,  wrM:0,  wrW:0,  rwM:1, rwW:1, expA:2'b00, expB:2'b00};
        vec[3] = '{rsE:6,  rtE:6,  wrM:6,  wrW:6,  rwM:0, rwW:1, expA:2'b01, expB:2'b01};
        vec[4] = '{rsE:8,  rtE:9,  wrM:9,  wrW:8,  rwM:1, rwW:0, expA:2'b00, expB:2'b10};
        vec[5] = '{rsE:31, rtE:31, wrM:31, wrW:31, rwM:1, rwW:1, expA:2'b10, expB:2'b10};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clearInputs();
            hzIf.RsE = vec[i].rsE; hzIf.RtE = vec[i].rtE;
            hzIf.WriteRegM = vec[i].wrM; hzIf.RegWriteM = vec[i].rwM;
            hzIf.WriteRegW = vec[i].wrW; hzIf.RegWriteW = vec[i].rwW;
            #1;
            checks++;
            if ({hzIf.ForwardAE, hzIf.ForwardBE} !== {vec[i].expA, vec[i].expB}) begin
                errors++;
                $display("[TB] FAIL fwdE[%0d] got A=%b B=%b exp A=%b B=%b", i,
                         hzIf.ForwardAE, hzIf.ForwardBE, vec[i].expA, vec[i].expB);
            end
        end
    endtask

    task automatic test_forward_decode();
        fwdD_t vec[4];
        vec[0] = '{rsD:4, rtD:5, wrM:4, rwM:1, expAD:1'b1, expBD:1'b0};
        vec[1] = '{rsD:4, rtD:5, wrM:5, rwM:1, expAD:1'b0, expBD:1'b1};
        vec[2] = '{rsD:0, rtD:0, wrM:0, rwM:1, expAD:1'b0, expBD:1'b0};
        vec[3] = '{rsD:6, rtD:6, wrM:6, rwM:0, expAD:1'b0, expBD:1'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clearInputs();
            hzIf.RsD = vec[i].rsD; hzIf.RtD = vec[i].rtD;
            hzIf.WriteRegM = vec[i].wrM; hzIf.RegWriteM = vec[i].rwM;
            #1;
            checks++;
            if ({hzIf.ForwardAD, hzIf.ForwardBD} !== {vec[i].expAD, vec[i].expBD}) begin
                errors++;
                $display("[TB] FAIL fwdD[%0d] got AD=%b BD=%b exp AD=%b BD=%b", i,
                         hzIf.ForwardAD, hzIf.ForwardBD, vec[i].expAD, vec[i].expBD);
            end
        end
    endtask

    task automatic test_load_use();
        // lw $3 in E, dependent instr reading $3 in D
        @(negedge clk);
        clearInputs();
        hzIf.MemtoRegE = 1'b1; hzIf.RegWriteE = 1'b1; hzIf.WriteRegE = 5'd3; hzIf.RtE = 5'd3;
        hzIf.RsD = 5'd3; hzIf.RtD = 5'd9;
        #1;
        checks++;
        if ({hzIf.StallF, hzIf.StallD, hzIf.FlushE} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL lwstall_first got=%b exp=111", {hzIf.StallF, hzIf.StallD, hzIf.FlushE});
        end
        // bubble in E, load moved to M, dependent instr still held in D
        @(negedge clk);
        clearInputs();
        hzIf.MemtoRegM = 1'b1; hzIf.RegWriteM = 1'b1; hzIf.WriteRegM = 5'd3;
        hzIf.RsD = 5'd3; hzIf.RtD = 5'd9;
        #1;
        checks++;
        if ({hzIf.StallF, hzIf.StallD, hzIf.FlushE} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL lwstall_second got=%b exp=000", {hzIf.StallF, hzIf.StallD, hzIf.FlushE});
        end
        // load in W, dependent instr in E picks up ResultW
        @(negedge clk);
        clearInputs();
        hzIf.RegWriteW = 1'b1; hzIf.WriteRegW = 5'd3;
        hzIf.RsE = 5'd3; hzIf.RtE = 5'd9;
        #1;
        checks++;
        if (hzIf.ForwardAE !== FWD_WB) begin
            errors++;
            $display("[TB] FAIL lw_forward got=%b exp=01", hzIf.ForwardAE);
        end
    endtask

    task automatic test_branch_stall();
        @(negedge clk);
        clearInputs();
        hzIf.BranchD = 1'b1; hzIf.RsD = 5'd4; hzIf.RtD = 5'd9;
        hzIf.RegWriteE = 1'b1; hzIf.WriteRegE = 5'd4;
        #1;
        checks++;
        if (hzIf.StallD !== 1'b1) begin
            errors++;
            $display("[TB] FAIL brstall_E got=%b exp=1", hzIf.StallD);
        end
        @(negedge clk);
        clearInputs();
        hzIf.BranchD = 1'b1; hzIf.RsD = 5'd4; hzIf.RtD = 5'd9;
        hzIf.RegWriteM = 1'b1; hzIf.WriteRegM = 5'd4;
        #1;
        checks++;
        if ({hzIf.StallF, hzIf.ForwardAD, hzIf.ForwardBD} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL brstall_M got stall/AD/BD=%b exp=010",
                     {hzIf.StallF, hzIf.ForwardAD, hzIf.ForwardBD});
        end
        // load in M feeding the branch must still stall
        @(negedge clk);
        clearInputs();
        hzIf.BranchD = 1'b1; hzIf.RsD = 5'd4; hzIf.RtD = 5'd9;
        hzIf.MemtoRegM = 1'b1; hzIf.RegWriteM = 1'b1; hzIf.WriteRegM = 5'd9;
        #1;
        checks++;
        if (hzIf.FlushE !== 1'b1) begin
            errors++;
            $display("[TB] FAIL brstall_loadM got=%b exp=1", hzIf.FlushE);
        end
        // $0 never creates a branch stall
        @(negedge clk);
        clearInputs();
        hzIf.BranchD = 1'b1; hzIf.RsD = 5'd0; hzIf.RtD = 5'd0;
        hzIf.RegWriteE = 1'b1; hzIf.WriteRegE = 5'd0;
        #1;
        checks++;
        if (hzIf.StallF !== 1'b0) begin
            errors++;
            $display("[TB] FAIL brstall_zero got=%b exp=0", hzIf.StallF);
        end
    endtask

    task automatic test_mdu_stall();
        pulseReset();
        clearInputs();
        hzIf.MdUseD = 1'b1;
        #1;
        checks++;
        if ({hzIf.StallF, hzIf.MdBusy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL md_idle got stall/busy=%b exp=00", {hzIf.StallF, hzIf.MdBusy});
        end
        // cycle t: start issued, user waiting in D
        @(negedge clk);
        hzIf.MdStartE = 1'b1;
        #1;
        checks++;
        if ({hzIf.StallF, hzIf.MdBusy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL md_t0 got stall/busy=%b exp=10", {hzIf.StallF, hzIf.MdBusy});
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            hzIf.MdStartE = 1'b0;
            #1;
            checks++;
            if ({hzIf.StallF, hzIf.MdBusy} !== ((k <= 4) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("[TB] FAIL md_t%0d got stall/busy=%b exp=%b", k,
                         {hzIf.StallF, hzIf.MdBusy}, (k <= 4) ? 2'b11 : 2'b00);
            end
        end
        checks++;
        if (hzIf.StallCount !== (PERF ? 32'd5 : 32'd0)) begin
            errors++;
            $display("[TB] FAIL md_stallcount got=%0d exp=%0d", hzIf.StallCount, PERF ? 5 : 0);
        end
    endtask

    task automatic test_mdu_reset();
        @(negedge clk);
        clearInputs();
        hzIf.MdUseD = 1'b1;
        hzIf.MdStartE = 1'b1;
        @(negedge clk);
        hzIf.MdStartE = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({hzIf.MdBusy, hzIf.StallF} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL md_reset got busy/stall=%b exp=00", {hzIf.MdBusy, hzIf.StallF});
        end
        checks++;
        if (hzIf.StallCount !== 32'h0) begin
            errors++;
            $display("[TB] FAIL md_reset_count got=%0d exp=0", hzIf.StallCount);
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (hzIf.MdBusy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL md_after_reset got=%b exp=0", hzIf.MdBusy);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_forward_execute();
        test_forward_decode();
        test_load_use();
        test_branch_stall();
        test_mdu_stall();
        test_mdu_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
